fpu_dispatch: RTL

Request-side front end for the `fpu` core. It accepts tagged operation requests from the issuing pipeline over a valid/ready channel and buffers them in a small FIFO. It issues them one at a time to the core, holding the operands stable for the core's fixed latency, and returns each result with its tag over a valid/ready response channel. It is the only block that drives the core's `start`/`op`/`a`/`b` inputs.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_req_fifo.sv | 72 +++++++
 rtl/fpu_dispatch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the fpu request path: opcodes, dispatcher FSM states and the buffered request word.
package fpu_pkg;

    localparam int FPU_LATENCY = 31;
    localparam int TAG_MAX_W   = 16;

    typedef enum logic [2:0] {
        OP_IDLE = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_DIV  = 3'b100,
        OP_SQRT = 3'b101,
        OP_MIN  = 3'b110,
        OP_MAX  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Tag field is sized for the widest user; narrower tags are zero-extended on push.
    typedef struct packed {
        op_e                  op;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [TAG_MAX_W-1:0] tag;
    } req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO of req_t entries; one-cycle write-to-read, registered count/full/empty.
// Push is ignored when full and pop when empty, so the pointers can never overrun.
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  req_t                   push_dat,
    input  logic                   pop,
    output req_t                   pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Buffers tagged requests and issues them one at a time to the fpu core, returning tagged results in order.
// Accept-to-rsp_valid is 34 cycles (2 for op 000); rsp_ready low parks the FSM in RESP while the FIFO keeps filling.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 2 * FPU_LATENCY
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [31:0]            req_a,
    input  logic [31:0]            req_b,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_err,
    output logic                   fpu_start,
    output logic [2:0]             fpu_op,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    input  logic [31:0]            fpu_result,
    input  logic                   fpu_rdy,
    output logic                   stray_err,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stray_q, stray_d;

    req_t fifo_push_dat;
    req_t fifo_head;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic unused_tag_hi;

    always_comb begin
        fifo_push_dat     = '0;
        fifo_push_dat.op  = op_e'(req_op);
        fifo_push_dat.a   = req_a;
        fifo_push_dat.b   = req_b;
        fifo_push_dat.tag = TAG_MAX_W'(req_tag);
    end

    assign req_ready     = !fifo_full;
    assign fifo_push     = req_valid && req_ready;
    assign unused_tag_hi = ^fifo_head.tag;

    fpu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        res_d    = res_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        stray_d  = stray_q | (fpu_rdy && (state_q != ST_WAIT));
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fifo_pop = !fifo_empty;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fpu_rdy) begin
                    res_d   = fpu_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    fifo_pop = !fifo_empty;
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared by IDLE and a RESP handshake: a no-op skips the core and answers directly.
        if (fifo_pop) begin
            op_d  = fifo_head.op;
            a_d   = fifo_head.a;
            b_d   = fifo_head.b;
            tag_d = fifo_head.tag[TAG_W-1:0];
            if (fifo_head.op != OP_IDLE) begin
                state_d = ST_ISSUE;
            end else begin
                res_d   = '0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            stray_q <= stray_d;
        end
    end

    assign fpu_start  = (state_q == ST_ISSUE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign fpu_op     = op_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign rsp_result = res_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;
    assign stray_err  = stray_q;

endmodule
